audio_i2s_tx: RTL



---
 rtl/audio_i2s_tx_pkg.sv | 15 +
 rtl/audio_i2s_tx.sv | 76 +++++++
 2 files changed

// File: rtl/audio_i2s_tx_pkg.sv
// Shared audio constants and the frame-length helper, which the PSG-side
// sample-rate documentation also uses.
package audio_i2s_tx_pkg;

    localparam int unsigned SAMPLE_WIDTH      = 16;
    localparam int unsigned DEFAULT_BCK_HALF  = 4;
    localparam int unsigned DEFAULT_SLOT_BITS = 32;

    // clk cycles per stereo frame: two slots of slot_bits BCK periods each
    function automatic int unsigned frame_len(input int unsigned bck_half,
                                              input int unsigned slot_bits);
        return 2 * slot_bits * 2 * bck_half;
    endfunction

endpackage

// File: rtl/audio_i2s_tx.sv
// Stereo Philips-I2S transmitter: paces the PSG with one next_sample strobe per
// frame, captures the sample pair at frame end and shifts it out MSB-first.
module audio_i2s_tx
    import audio_i2s_tx_pkg::*;
#(
    parameter int unsigned BCK_HALF  = DEFAULT_BCK_HALF,
    parameter int unsigned SLOT_BITS = DEFAULT_SLOT_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] left_audio,
    input  logic [SAMPLE_WIDTH-1:0] right_audio,
    output logic                    next_sample,
    output logic                    i2s_lrck,
    output logic                    i2s_bck,
    output logic                    i2s_data
);

    localparam int unsigned FRAME   = frame_len(BCK_HALF, SLOT_BITS);
    localparam int unsigned CNT_W   = $clog2(FRAME);
    localparam int unsigned BCK_BIT = $clog2(BCK_HALF);
    localparam int unsigned FW_W    = 2 * SLOT_BITS;
    localparam int unsigned PAD_W   = SLOT_BITS - SAMPLE_WIDTH;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FW_W-1:0]  shift_q, shift_d;
    logic             data_q, data_d;
    logic             strobe_q, strobe_d;
    logic [FW_W-1:0]  frame_word;
    logic             frame_end;
    logic             slot_end;

    always_comb begin
        frame_word = {left_audio, {PAD_W{1'b0}}, right_audio, {PAD_W{1'b0}}};
        frame_end  = (cnt_q == CNT_LAST);
        // Last cycle of a BCK period, i.e. the cycle before BCK falls
        slot_end   = &cnt_q[BCK_BIT:0];

        cnt_d    = cnt_q + CNT_W'(1);
        shift_d  = shift_q;
        data_d   = data_q;
        strobe_d = (cnt_q == '0);

        if (frame_end) begin
            // Slot 0 carries a zero: the one-BCK Philips delay after LRCK
            shift_d = frame_word;
            data_d  = 1'b0;
        end else if (slot_end) begin
            data_d  = shift_q[FW_W-1];
            shift_d = {shift_q[FW_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt_q    <= '0;
            shift_q  <= '0;
            data_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    assign next_sample = strobe_q;
    assign i2s_bck     = cnt_q[BCK_BIT];
    assign i2s_lrck    = cnt_q[CNT_W-1];
    assign i2s_data    = data_q;

endmodule
